// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC sequencer.
// Owns the fetch PC and resolves X-stage redirects. A redirect seen while an
// instruction-memory access is outstanding is parked in a one-entry pending
// buffer. That redirect is applied once the access completes. Each redirect
// opens a counted flush window that squashes wrong-path F/D instructions.
// Optional feature macro: FETCH_PC_CTRL_STATS_EN adds saturating counters for
// taken and not-taken conditional branches. Without it, those ports read 0.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_rdy,
  input  logic        x_valid,
  input  logic        x_is_jal,
  input  logic        x_is_branch,
  input  logic [2:0]  x_func3,
  input  logic        breq,
  input  logic        brlt,
  input  logic [31:0] x_target,
  output logic [31:0] pc,
  output logic [1:0]  pc_sel,
  output logic        fetch_valid,
  output logic        kill,
  output logic        redirect,
  output logic        illegal_br,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_ntaken_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;

  logic        br_cond;
  logic        f3_illegal;
  logic        x_live;
  logic        take;
  logic [31:0] pc_inc;

  // Branch condition decode from funct3 and comparator flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    br_cond    = 1'b0;
    f3_illegal = 1'b0;
    case (x_func3)
      3'b000:         br_cond = breq;
      3'b001:         br_cond = !breq;
      3'b100, 3'b110: br_cond = brlt;
      3'b101, 3'b111: br_cond = !brlt;
      default:        f3_illegal = 1'b1;
    endcase
  end

  // X inputs are only honoured once booted and outside the flush window.
  assign x_live = x_valid && (state_q == S_RUN || state_q == S_WAIT);
  assign take   = x_live && (x_is_jal || (x_is_branch && br_cond));
  assign pc_inc = pc_q + 32'd4;

  // Next-state logic. Priority: redirect, then imem wait, then stall, then sequential.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (take) begin
          pc_d    = x_target;
          cnt_d   = FLUSH_LOAD;
          state_d = S_FLUSH;
        end else if (!imem_rdy) begin
          state_d = S_WAIT;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
      S_WAIT: begin
        if (imem_rdy) begin
          if (take || pend_v_q) begin
            // A redirect arriving on the completing cycle is newer than the parked one.
            pc_d     = take ? x_target : pend_q;
            pend_v_d = 1'b0;
            cnt_d    = FLUSH_LOAD;
            state_d  = S_FLUSH;
          end else begin
            state_d = S_RUN;
            if (!stall) pc_d = pc_inc;
          end
        end else if (take) begin
          // The address must not change mid-access, so the redirect is parked.
          pend_d   = x_target;
          pend_v_d = 1'b1;
        end
      end
      S_FLUSH: begin
        // An outstanding access freezes both the PC and the flush countdown.
        if (imem_rdy) begin
          if (!stall) pc_d = pc_inc;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State registers with asynchronous reset to the boot vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= 3'd0;
      pend_q   <= 32'd0;
      pend_v_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign pc          = pc_q;
  assign kill        = (state_q == S_FLUSH);
  assign fetch_valid = imem_rdy && !stall && (state_q == S_RUN || state_q == S_FLUSH);
  assign redirect    = take;
  assign pc_sel      = take ? (x_is_jal ? 2'd0 : 2'd1) : 2'd2;
  assign illegal_br  = x_valid && x_is_branch && f3_illegal;

`ifdef FETCH_PC_CTRL_STATS_EN
  logic        br_eval;
  logic [31:0] tk_q, nt_q;

  assign br_eval = x_live && x_is_branch && !x_is_jal;

  // Saturating counters of evaluated conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tk_q <= 32'd0;
      nt_q <= 32'd0;
    end else if (br_eval) begin
      if (br_cond && tk_q != '1)  tk_q <= tk_q + 32'd1;
      if (!br_cond && nt_q != '1) nt_q <= nt_q + 32'd1;
    end
  end

  assign br_taken_cnt  = tk_q;
  assign br_ntaken_cnt = nt_q;
`else
  assign br_taken_cnt  = 32'd0;
  assign br_ntaken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed bench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_rdy;
  logic        x_valid;
  logic        x_is_jal;
  logic        x_is_branch;
  logic [2:0]  x_func3;
  logic        breq;
  logic        brlt;
  logic [31:0] x_target;
  logic [31:0] pc;
  logic [1:0]  pc_sel;
  logic        fetch_valid;
  logic        kill;
  logic        redirect;
  logic        illegal_br;
  logic [31:0] br_taken_cnt;
  logic [31:0] br_ntaken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .imem_rdy      (imem_rdy),
    .x_valid       (x_valid),
    .x_is_jal      (x_is_jal),
    .x_is_branch   (x_is_branch),
    .x_func3       (x_func3),
    .breq          (breq),
    .brlt          (brlt),
    .x_target      (x_target),
    .pc            (pc),
    .pc_sel        (pc_sel),
    .fetch_valid   (fetch_valid),
    .kill          (kill),
    .redirect      (redirect),
    .illegal_br    (illegal_br),
    .br_taken_cnt  (br_taken_cnt),
    .br_ntaken_cnt (br_ntaken_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_x();
    x_valid     = 1'b0;
    x_is_jal    = 1'b0;
    x_is_branch = 1'b0;
    x_func3     = 3'b000;
    breq        = 1'b0;
    brlt        = 1'b0;
    x_target    = 32'h0;
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    imem_rdy = 1'b1;
    clear_x();

    // Reset state
    #12;
    check("rst_pc", pc, 32'h4000_0000);
    check("rst_pc_sel", 32'(pc_sel), 32'd2);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_kill", 32'(kill), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_illegal", 32'(illegal_br), 32'd0);

    // Release just after an edge so the next full cycle is BOOT
    tick();
    rst_n = 1'b1;
    #1;
    check("boot_pc", pc, 32'h4000_0000);
    check("boot_fv", 32'(fetch_valid), 32'd0);
    check("boot_kill", 32'(kill), 32'd0);
    tick();
    check("run0_pc", pc, 32'h4000_0000);
    check("run0_fv", 32'(fetch_valid), 32'd1);
    tick();
    check("run1_pc", pc, 32'h4000_0004);
    check("run1_fv", 32'(fetch_valid), 32'd1);
    check("run1_kill", 32'(kill), 32'd0);
    tick();
    check("run2_pc", pc, 32'h4000_0008);

    // BEQ taken
    x_valid = 1'b1; x_is_branch = 1'b1; x_func3 = 3'b000; breq = 1'b1;
    x_target = 32'h4000_0100;
    #1;
    check("beq_pc_sel", 32'(pc_sel), 32'd1);
    check("beq_redirect", 32'(redirect), 32'd1);
    tick();
    check("beq_pc", pc, 32'h4000_0100);
    check("beq_kill1", 32'(kill), 32'd1);
    // A live jal inside the flush window must be ignored
    x_is_branch = 1'b0; x_is_jal = 1'b1; x_target = 32'h1234_5670;
    #1;
    check("flush_ign_redirect", 32'(redirect), 32'd0);
    check("flush_ign_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    check("beq_pc2", pc, 32'h4000_0104);
    check("beq_kill2", 32'(kill), 32'd1);
    check("flush_ign_redirect2", 32'(redirect), 32'd0);
    tick();
    check("beq_pc3", pc, 32'h4000_0108);
    check("beq_kill_end", 32'(kill), 32'd0);

    // BGEU not taken (brlt=1)
    clear_x();
    x_valid = 1'b1; x_is_branch = 1'b1; x_func3 = 3'b111; brlt = 1'b1;
    x_target = 32'h4000_0F00;
    #1;
    check("bgeu_pc_sel", 32'(pc_sel), 32'd2);
    check("bgeu_redirect", 32'(redirect), 32'd0);
    check("bgeu_illegal", 32'(illegal_br), 32'd0);
    tick();
    check("bgeu_pc", pc, 32'h4000_010C);
    check("bgeu_kill", 32'(kill), 32'd0);
    // Illegal funct3 010
    x_func3 = 3'b010; breq = 1'b1;
    #1;
    check("ill_flag", 32'(illegal_br), 32'd1);
    check("ill_redirect", 32'(redirect), 32'd0);
    check("ill_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    check("ill_pc", pc, 32'h4000_0110);
    clear_x();

    // WAIT with redirect parked in the pending buffer
    imem_rdy = 1'b0;
    #1;
    check("wait_a_fv", 32'(fetch_valid), 32'd0);
    tick();
    x_valid = 1'b1; x_is_jal = 1'b1; x_target = 32'h4000_0200;
    #1;
    check("wait_b_pc", pc, 32'h4000_0110);
    check("wait_b_redirect", 32'(redirect), 32'd1);
    check("wait_b_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    clear_x();
    #1;
    check("wait_c_pc", pc, 32'h4000_0110);
    tick();
    imem_rdy = 1'b1;
    #1;
    check("wait_d_pc", pc, 32'h4000_0110);
    check("wait_d_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("wait_tgt_pc", pc, 32'h4000_0200);
    check("wait_tgt_kill", 32'(kill), 32'd1);
    tick();
    check("wait_fl_pc", pc, 32'h4000_0204);
    check("wait_fl_kill", 32'(kill), 32'd1);
    tick();
    check("wait_end_pc", pc, 32'h4000_0208);
    check("wait_end_kill", 32'(kill), 32'd0);

    // Redirect coincident with stall, then wrap, with an imem freeze inside flush
    stall = 1'b1;
    x_valid = 1'b1; x_is_jal = 1'b1; x_target = 32'hFFFF_FFFC;
    #1;
    check("stj_redirect", 32'(redirect), 32'd1);
    check("stj_pc_sel", 32'(pc_sel), 32'd0);
    check("stj_fv", 32'(fetch_valid), 32'd0);
    tick();
    check("stj_pc", pc, 32'hFFFF_FFFC);
    check("stj_kill", 32'(kill), 32'd1);
    clear_x();
    stall = 1'b0;
    imem_rdy = 1'b0;
    tick();
    check("frz_pc", pc, 32'hFFFF_FFFC);
    check("frz_kill", 32'(kill), 32'd1);
    imem_rdy = 1'b1;
    tick();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_kill", 32'(kill), 32'd1);
    tick();
    check("wrap_pc2", pc, 32'h0000_0004);
    check("wrap_kill_end", 32'(kill), 32'd0);
    // Plain stall holds pc in RUN
    stall = 1'b1;
    tick();
    check("stall_pc", pc, 32'h0000_0004);
    stall = 1'b0;

    // Async reset in the middle of a flush
    x_valid = 1'b1; x_is_jal = 1'b1; x_target = 32'h4000_0300;
    tick();
    clear_x();
    check("fl_pc", pc, 32'h4000_0300);
    check("fl_kill", 32'(kill), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h4000_0000);
    check("arst_kill", 32'(kill), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_run_pc", pc, 32'h4000_0000);
    check("arst_run_fv", 32'(fetch_valid), 32'd1);

    // Reset clears a parked redirect
    imem_rdy = 1'b0;
    tick();
    x_valid = 1'b1; x_is_jal = 1'b1; x_target = 32'h4000_0500;
    tick();
    clear_x();
    rst_n = 1'b0;
    #1;
    check("pend_rst_pc", pc, 32'h4000_0000);
    tick();
    rst_n = 1'b1;
    imem_rdy = 1'b1;
    tick();
    imem_rdy = 1'b0;
    tick();
    imem_rdy = 1'b1;
    tick();
    check("pend_clr_pc", pc, 32'h4000_0004);
    check("pend_clr_kill", 32'(kill), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage PC sequencer. Owns the architectural fetch PC register and drives the select for the next-PC mux (0 jump, 1 branch, 2 PC+4). Resolves branch/jump redirects arriving from the X stage, holds the fetch address stable across instruction-memory wait states, and squashes wrong-path instructions in F/D with a counted flush window. Sits between the X-stage branch comparator/ALU and the instruction-memory address port.

## Interface
- `RESET_PC`, 32'h4000_0000, fetch address loaded on reset.
- `FLUSH_CYCLES`, 2, cycles `kill` stays high after a redirect (1..7).

- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: downstream hazard hold; freezes sequential advance.
- `imem_rdy` in 1: instruction memory accepts/returns the access at `pc` this cycle.
- `x_valid` in 1: X-stage instruction is live.
- `x_is_jal` in 1: X instruction is jal/jalr.
- `x_is_branch` in 1: X instruction is a conditional branch.
- `x_func3` in 3: X instruction funct3.
- `breq`, `brlt` in 1 each: comparator results for X instruction.
- `x_target` in 32: ALU-computed target for X instruction.
- `pc` out 32: current fetch address (registered).
- `pc_sel` out 2: mux select applied this cycle (0 jump, 1 branch taken, 2 sequential).
- `fetch_valid` out 1: `pc` fetch completes this cycle (`imem_rdy` & state RUN/FLUSH & !`stall`).
- `kill` out 1: squash instruction in F/D.
- `redirect` out 1: a redirect was accepted this cycle.
- `illegal_br` out 1: branch with funct3 010/011 seen (pulse).

## Operation
- Taken decode: 000 breq; 001 !breq; 100/110 brlt; 101/111 !brlt; 010/011 not taken + `illegal_br`=1.
- `take` = `x_valid` & state≠BOOT & state≠FLUSH & (`x_is_jal` | (`x_is_branch` & taken)). `x_valid` is ignored in FLUSH.
- States: BOOT, RUN, WAIT, FLUSH.
- BOOT: entered on reset; `pc`=RESET_PC; next cycle → RUN. No fetch_valid, kill=0.
- RUN: `take` → `pc`<=`x_target`, counter<=FLUSH_CYCLES, → FLUSH. Else `imem_rdy`=0 → WAIT, `pc` held. Else `stall` → hold. Else `pc`<=`pc`+4.
- WAIT: `pc` held stable (address must not change mid-access). `take` latches `x_target` into one-entry pending buffer (later redirect overwrites). On `imem_rdy`=1: pending valid → `pc`<=pending, clear, → FLUSH with counter reload; else → RUN and advance per RUN rules.
- FLUSH: `kill`=1; counter decrements each cycle; `pc` advances as in RUN (stall/imem_rdy respected, imem_rdy=0 freezes counter too); counter reaching 1 → RUN next cycle.
- Priority: reset > redirect > imem wait > stall > sequential. Redirect coincident with `stall` is taken.
- `pc_sel`: 0 when jal accepted, 1 when branch accepted, 2 otherwise. `pc`+4 wraps modulo 2^32.

## Timing
- Reset values: `pc`=RESET_PC, `pc_sel`=2, `fetch_valid`=0, `kill`=0, `redirect`=0, `illegal_br`=0, pending buffer invalid, counter 0, state BOOT.
- Reset deassertion mid-operation: all state returns to above asynchronously; first fetch_valid two cycles after `rst_n` rises (BOOT, then RUN).
- Redirect latency: `take` in cycle N → `pc`=target in N+1, `kill`=1 cycles N+1..N+FLUSH_CYCLES (no waits).
- `redirect`, `pc_sel`, `illegal_br` combinational from current-cycle X inputs; `pc`, `kill`, `fetch_valid` derived from registered state.
- `pc` at 32'hFFFF_FFFC advancing → 32'h0000_0000.

## Configuration
- `FETCH_PC_CTRL_STATS_EN`: defined → two 32-bit saturating counters `br_taken_cnt`, `br_ntaken_cnt` (extra outputs) count accepted conditional branches, clear on reset; undefined → ports present, tied to 0, no counter logic.

## Test plan
- Reset: `rst_n`=0 then 1 -> `pc`=4000_0000 for BOOT cycle, then 4000_0004, 4000_0008 with fetch_valid=1, kill=0.
- BEQ taken: func3=000, breq=1, x_target=4000_0100 -> pc_sel=1, next `pc`=4000_0100, kill=1 for exactly 2 cycles, x_valid ignored during them.
- BGEU not taken: func3=111, brlt=1 -> pc_sel=2, `pc` +4, kill stays 0; func3=010 -> illegal_br=1, no redirect.
- WAIT + redirect: imem_rdy=0 for 3 cycles, jal to 4000_0200 in cycle 2 -> `pc` held, then 4000_0200 the cycle after imem_rdy=1, then FLUSH.
- Redirect during stall, and wrap: stall=1 with jal to FFFF_FFFC -> `pc`=FFFF_FFFC next cycle, then 0000_0000.
- Async reset in FLUSH: rst_n low mid-flush -> kill=0, `pc`=4000_0000 immediately, pending cleared.
